// File: rtl/adder_result_accumulator.sv
// Sums WINDOW consecutive adder results; saturates at the accumulator width and flags overflow.
// Latency: out_valid rises the cycle after the WINDOW-th accepted sample; back-to-back windows run without bubbles.
// Backpressure: while a result is held, in_ready follows out_ready combinationally. Optional `ACCUMULATOR_AVERAGE_EN turns the sum into a rounded average.
module adder_result_accumulator #(
    parameter int WIDTH     = 17,
    parameter int WINDOW    = 4,
    parameter int ACC_WIDTH = 19,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic [CNT_WIDTH-1:0] sample_cnt
);

    // The adder width covers both operands plus one carry bit. The carry bit detects
    // overflow even when in_data is wider than the accumulator.
    localparam int SUM_W = ((WIDTH > ACC_WIDTH) ? WIDTH : ACC_WIDTH) + 1;
    localparam logic [SUM_W-1:0]     ACC_MAX = {{(SUM_W-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};
    localparam logic [CNT_WIDTH-1:0] WIN     = CNT_WIDTH'(WINDOW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt;
    logic                 ovf, ovf_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

    logic                 accept;
    logic                 start;
    logic                 last;
    logic                 clamp;
    logic [SUM_W-1:0]     base;
    logic [SUM_W-1:0]     sum;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Handshake and datapath for the sample arriving this cycle.
    always_comb begin
        in_ready = (state != S_HOLD) || out_ready;
        accept   = in_valid && in_ready;
        // An accept in IDLE, or in HOLD while the held result drains, opens a fresh window.
        start    = (state != S_ACCUM);
        base     = start ? '0 : SUM_W'(acc);
        sum      = base + SUM_W'(in_data);
        // The clamp is sticky for the whole window. After saturation acc must never leave all-ones.
        clamp    = (sum > ACC_MAX) || (!start && ovf);
        cnt_inc  = start ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
        last     = (cnt_inc == WIN);
    end

    // Next-state logic: fold in the accepted sample, or drop to IDLE once the result drains.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        cnt_nxt   = cnt;
        if (accept) begin
            acc_nxt   = clamp ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
            ovf_nxt   = clamp;
            cnt_nxt   = cnt_inc;
            state_nxt = last ? S_HOLD : S_ACCUM;
        end else if ((state == S_HOLD) && out_ready) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    // State register with synchronous reset. Reset discards any partial window.
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= S_IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign out_valid  = (state == S_HOLD);
    assign out_ovf    = ovf;
    assign sample_cnt = cnt;

`ifdef ACCUMULATOR_AVERAGE_EN
    localparam int SHIFT = $clog2(WINDOW);
    localparam int RND_I = (SHIFT == 0) ? 0 : (1 << (SHIFT - 1));

    // A shift can only divide by the window length when that length is a power of two.
    generate
        if ((WINDOW & (WINDOW - 1)) != 0) begin : g_window_not_pow2
            $error("adder_result_accumulator: WINDOW must be a power of two when averaging");
        end
    endgenerate

    logic [ACC_WIDTH:0]   rnd_sum;
    logic [ACC_WIDTH-1:0] rnd_sat;

    // Round half-up. The rounding add saturates so a clamped sum cannot wrap to a small average.
    always_comb begin
        rnd_sum = {1'b0, acc} + (ACC_WIDTH+1)'(RND_I);
        rnd_sat = rnd_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : rnd_sum[ACC_WIDTH-1:0];
        out_sum = rnd_sat >> SHIFT;
    end
`else
    assign out_sum = acc;
`endif

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator. Two instances share the same stimulus: the default 19-bit accumulator and a 17-bit one that saturates.
// Expected window results go into per-instance queues when a window's last sample is driven, and are compared when the output handshake happens.
// Also covers reset, sample_cnt progression, backpressure stall and a reset in the middle of a window.
module tb_adder_result_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [16:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_ovf0;
    logic [18:0] out_sum0;
    logic [15:0] sample_cnt0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [16:0] out_sum1;
    logic [15:0] sample_cnt1;

    adder_result_accumulator #(.WIDTH(17), .WINDOW(4), .ACC_WIDTH(19), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0), .out_ovf(out_ovf0),
        .sample_cnt(sample_cnt0)
    );

    adder_result_accumulator #(.WIDTH(17), .WINDOW(4), .ACC_WIDTH(17), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1), .out_ovf(out_ovf1),
        .sample_cnt(sample_cnt1)
    );

    typedef struct packed {
        logic        ovf;
        logic [31:0] sum;
    } exp_t;

    typedef struct packed {
        logic [3:0][16:0] d;
        logic [31:0]      s0;
        logic             o0;
        logic [31:0]      s1;
        logic             o1;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[7];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference for the presented value: the raw sum, or the half-up rounded average of the saturated sum.
    function automatic logic [31:0] present(input logic [31:0] s, input logic [31:0] maxv);
        logic [31:0] r;
`ifdef ACCUMULATOR_AVERAGE_EN
        r = s + 32'd2;
        if (r > maxv) r = maxv;
        return r >> 2;
`else
        r = s;
        if (r > maxv) r = maxv;
        return r;
`endif
    endfunction

    task automatic push_exp(input logic [31:0] s0, input logic o0, input logic [31:0] s1, input logic o1);
        q0.push_back('{ovf: o0, sum: present(s0, 32'h7FFFF)});
        q1.push_back('{ovf: o1, sum: present(s1, 32'h1FFFF)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: compare each output handshake against the oldest expected window.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_ready && out_valid0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_output: got sum 0x%0h expected no output", out_sum0);
            end else begin
                e = q0.pop_front();
                chk("dut0_sum", 32'(out_sum0), e.sum);
                chk("dut0_ovf", 32'(out_ovf0), 32'(e.ovf));
                chk("dut0_cnt_hold", 32'(sample_cnt0), 32'd4);
            end
        end
        if (!rst && out_ready && out_valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_output: got sum 0x%0h expected no output", out_sum1);
            end else begin
                e = q1.pop_front();
                chk("dut1_sum", 32'(out_sum1), e.sum);
                chk("dut1_ovf", 32'(out_ovf1), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        // Each record is one window, with the expected raw sums for the 19-bit and the 17-bit accumulators.
        tbl[0] = '{d: {17'd40, 17'd30, 17'd20, 17'd10}, s0: 32'd100, o0: 1'b0, s1: 32'd100, o1: 1'b0};
        tbl[1] = '{d: {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF}, s0: 32'h7FFFC, o0: 1'b0, s1: 32'h1FFFF, o1: 1'b1};
        tbl[2] = '{d: {17'd1, 17'd1, 17'd1, 17'd1}, s0: 32'd4, o0: 1'b0, s1: 32'd4, o1: 1'b0};
        tbl[3] = '{d: {17'd0, 17'd0, 17'd1, 17'h1FFFF}, s0: 32'h20000, o0: 1'b0, s1: 32'h1FFFF, o1: 1'b1};
        tbl[4] = '{d: {17'd7, 17'd0, 17'd0, 17'd5}, s0: 32'd12, o0: 1'b0, s1: 32'd12, o1: 1'b0};
        tbl[5] = '{d: {17'd0, 17'd0, 17'd0, 17'd0}, s0: 32'd0, o0: 1'b0, s1: 32'd0, o1: 1'b0};
        tbl[6] = '{d: {17'd0, 17'd0, 17'h10000, 17'h10000}, s0: 32'h20000, o0: 1'b0, s1: 32'h1FFFF, o1: 1'b1};

        // Reset is held for two cycles with a valid sample present. Nothing may be taken in.
        rst = 1'b1; in_valid = 1'b1; in_data = 17'd5; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_out_valid", 32'(out_valid0), 32'd0);
            chk("rst_out_sum", 32'(out_sum0), 32'd0);
            chk("rst_sample_cnt", 32'(sample_cnt0), 32'd0);
            chk("rst_in_ready", 32'(in_ready0), 32'd1);
            chk("rst_ovf", 32'(out_ovf0), 32'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_rst_cnt", 32'(sample_cnt0), 32'd0);

        // Windows run back to back with out_ready=1. Every cycle accepts a sample, with no bubbles.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 4; j++) begin
                in_valid = 1'b1;
                in_data  = tbl[i].d[j];
                if (j == 3) push_exp(tbl[i].s0, tbl[i].o0, tbl[i].s1, tbl[i].o1);
                tick();
                chk("stream_cnt0", 32'(sample_cnt0), 32'(j + 1));
                chk("stream_cnt1", 32'(sample_cnt1), 32'(j + 1));
                chk("stream_in_ready", 32'(in_ready0), 32'd1);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid0", 32'(out_valid0), 32'd0);
        chk("drain_out_valid1", 32'(out_valid1), 32'd0);

        // Backpressure: the result is held while out_ready=0. A waiting sample is not taken until out_ready returns.
        out_ready = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            in_valid = 1'b1;
            in_data  = 17'(j);
            if (j == 4) push_exp(32'd10, 1'b0, 32'd10, 1'b0);
            tick();
        end
        in_data = 17'd7;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_in_ready", 32'(in_ready0), 32'd0);
            chk("stall_out_valid", 32'(out_valid0), 32'd1);
            chk("stall_out_sum", 32'(out_sum0), present(32'd10, 32'h7FFFF));
        end
        out_ready = 1'b1;
        tick();
        chk("restart_cnt", 32'(sample_cnt0), 32'd1);
        chk("restart_out_valid", 32'(out_valid0), 32'd0);
        for (int j = 0; j < 3; j++) begin
            in_data = 17'd1;
            if (j == 2) push_exp(32'd10, 1'b0, 32'd10, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();

        // A reset in the middle of a window discards the partial sum of 300.
        in_valid = 1'b1; in_data = 17'd100; tick();
        in_data = 17'd200; tick();
        chk("partial_cnt", 32'(sample_cnt0), 32'd2);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("midrst_cnt", 32'(sample_cnt0), 32'd0);
        chk("midrst_out_valid", 32'(out_valid0), 32'd0);
        rst = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            in_valid = 1'b1;
            in_data  = 17'(j);
            if (j == 4) push_exp(32'd10, 1'b0, 32'd10, 1'b0);
            tick();
            in_valid = 1'b0;
            tick();
            tick();
        end
        chk("gap_end_out_valid", 32'(out_valid0), 32'd0);
        chk("gap_end_cnt", 32'(sample_cnt0), 32'd0);

        // Every expected window must have been produced within a bounded number of cycles.
        for (int c = 0; c < 10 && (q0.size() != 0 || q1.size() != 0); c++) tick();
        chk("dut0_missing_outputs", 32'(q0.size()), 32'd0);
        chk("dut1_missing_outputs", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
